// File: rtl/soc_event_queue_rr.sv
// soc_event_queue_rr
//   Per-channel saturating event counters (QUEUE_SIZE deep) drained through a
//   single valid/ready port by a round-robin arbiter. Each offered event
//   carries its source channel ID.
//
// Ports
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   event_i         per-channel event pulses; a bit high N cycles = N events
//   err_o           per-channel overflow pulse, same cycle as the dropped event
//   pending_o       per-channel registered count != 0
//   evt_valid_o     event offered (registered)
//   evt_id_o        channel of offered event (registered, stable until accepted)
//   evt_ready_i     consumer accept
//
// Optional build macro SOC_EVT_QUEUE_STICKY_ERR_EN
//   adds err_sticky_o (set by err_o, cleared by err_clr_i, set wins) and
//   err_clr_i. Without it, overflow is only reported by err_o pulses.

module soc_event_queue_rr #(
  parameter  int unsigned NB_CH      = 8,
  parameter  int unsigned QUEUE_SIZE = 4,
  localparam int unsigned CNT_W      = $clog2(QUEUE_SIZE + 1),
  localparam int unsigned ID_W       = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [NB_CH-1:0] event_i,
  output logic [NB_CH-1:0] err_o,
  output logic [NB_CH-1:0] pending_o,
  output logic             evt_valid_o,
  output logic [ID_W-1:0]  evt_id_o,
  input  logic             evt_ready_i
`ifdef SOC_EVT_QUEUE_STICKY_ERR_EN
  ,
  output logic [NB_CH-1:0] err_sticky_o,
  input  logic [NB_CH-1:0] err_clr_i
`endif
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NB_CH];
  logic [CNT_W-1:0] cnt_d [NB_CH];
  logic [ID_W-1:0]  evt_id_q, evt_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NB_CH-1:0] nz_q, nz_d;
  logic             hs;

  // First set bit of nz at or above ptr, wrapping to the bottom.
  function automatic logic [ID_W-1:0] pick(input logic [NB_CH-1:0] nz,
                                           input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] res;
    logic            found;
    res   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < NB_CH; j++) begin
      if (!found && (j >= 32'(ptr)) && nz[j]) begin
        res   = ID_W'(j);
        found = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NB_CH; j++) begin
      if (!found && (j < 32'(ptr)) && nz[j]) begin
        res   = ID_W'(j);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign hs          = evt_valid_o & evt_ready_i;
  assign evt_valid_o = (state_q == S_OFFER);
  assign evt_id_o    = evt_id_q;
  assign pending_o   = nz_q;

  // Counter update, overflow detection and next-cycle occupancy.
  always_comb begin
    cnt_d = cnt_q;
    err_o = '0;
    nz_d  = '0;
    nz_q  = '0;
    for (int unsigned c = 0; c < NB_CH; c++) begin
      nz_q[c] = (cnt_q[c] != '0);
      if (event_i[c] && !(hs && (evt_id_q == ID_W'(c)))) begin
        if (cnt_q[c] != CNT_W'(QUEUE_SIZE)) begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end else begin
          err_o[c] = 1'b1;
        end
      end else if (!event_i[c] && hs && (evt_id_q == ID_W'(c))) begin
        cnt_d[c] = cnt_q[c] - CNT_W'(1);
      end
      nz_d[c] = (cnt_d[c] != '0);
    end
  end

  // Arbiter FSM: IDLE picks from registered counts; OFFER re-picks from
  // post-update counts on a handshake so transfers can run back to back.
  always_comb begin
    state_d  = state_q;
    evt_id_d = evt_id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|nz_q) begin
          evt_id_d = pick(nz_q, rr_ptr_q);
          state_d  = S_OFFER;
        end
      end
      S_OFFER: begin
        if (hs) begin
          rr_ptr_d = (evt_id_q == ID_W'(NB_CH - 1)) ? '0 : evt_id_q + ID_W'(1);
          if (|nz_d) begin
            evt_id_d = pick(nz_d, rr_ptr_d);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      evt_id_q <= '0;
      rr_ptr_q <= '0;
      for (int unsigned c = 0; c < NB_CH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      evt_id_q <= evt_id_d;
      rr_ptr_q <= rr_ptr_d;
      for (int unsigned c = 0; c < NB_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

`ifdef SOC_EVT_QUEUE_STICKY_ERR_EN
  logic [NB_CH-1:0] err_sticky_q, err_sticky_d;

  // Set has priority over clear.
  always_comb begin
    err_sticky_d = (err_sticky_q & ~err_clr_i) | err_o;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_sticky_q <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky_o = err_sticky_q;
`endif

endmodule

// File: tb/tb_soc_event_queue_rr.sv
module tb_soc_event_queue_rr;

  localparam int unsigned NB_CH = 8;
  localparam int unsigned QS    = 4;
  localparam int unsigned ID_W  = 3;

  logic             clk_i = 1'b0;
  logic             rstn_i = 1'b0;
  logic [NB_CH-1:0] event_i = '0;
  logic [NB_CH-1:0] err_o;
  logic [NB_CH-1:0] pending_o;
  logic             evt_valid_o;
  logic [ID_W-1:0]  evt_id_o;
  logic             evt_ready_i = 1'b0;
`ifdef SOC_EVT_QUEUE_STICKY_ERR_EN
  logic [NB_CH-1:0] err_sticky_o;
  logic [NB_CH-1:0] err_clr_i = '0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  soc_event_queue_rr #(.NB_CH(NB_CH), .QUEUE_SIZE(QS)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .event_i     (event_i),
    .err_o       (err_o),
    .pending_o   (pending_o),
    .evt_valid_o (evt_valid_o),
    .evt_id_o    (evt_id_o),
    .evt_ready_i (evt_ready_i)
`ifdef SOC_EVT_QUEUE_STICKY_ERR_EN
    ,
    .err_sticky_o(err_sticky_o),
    .err_clr_i   (err_clr_i)
`endif
  );

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rstn_i      = 1'b0;
    event_i     = '0;
    evt_ready_i = 1'b0;
    repeat (2) tick();
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    event_i = '0;
    evt_ready_i = 1'b0;
    tick(); #1;
    checks++;
    if ({evt_valid_o, evt_id_o, pending_o, err_o} !== '0) begin
      failures++;
      $display("FAIL reset_state: valid=%b id=%0d pend=%b err=%b, required all 0",
               evt_valid_o, evt_id_o, pending_o, err_o);
    end
    tick();
    rstn_i = 1'b1;
    repeat (3) tick();
    #1;
    checks++;
    if ({evt_valid_o, pending_o} !== '0) begin
      failures++;
      $display("FAIL reset_idle: valid=%b pend=%b, required 0", evt_valid_o, pending_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    tick(); event_i = 8'h08; evt_ready_i = 1'b1; #1;
    checks++;
    if (evt_valid_o !== 1'b0 || pending_o !== 8'h00) begin
      failures++;
      $display("FAIL single_t0: valid=%b pend=%b, required 0/00", evt_valid_o, pending_o);
    end
    tick(); event_i = '0; #1;
    checks++;
    if (evt_valid_o !== 1'b0 || pending_o !== 8'h08) begin
      failures++;
      $display("FAIL single_t1: valid=%b pend=%b, required 0/08", evt_valid_o, pending_o);
    end
    tick(); #1;
    checks++;
    if (evt_valid_o !== 1'b1 || evt_id_o !== 3'd3) begin
      failures++;
      $display("FAIL single_t2: valid=%b id=%0d, required 1/3", evt_valid_o, evt_id_o);
    end
    tick(); #1;
    checks++;
    if (evt_valid_o !== 1'b0 || pending_o !== 8'h00) begin
      failures++;
      $display("FAIL single_t3: valid=%b pend=%b, required 0/00", evt_valid_o, pending_o);
    end
    evt_ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    logic [5:0] exp_err;
    exp_err = 6'b110000;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(); event_i = 8'h01; #1;
      checks++;
      if (err_o[0] !== exp_err[i] || err_o[7:1] !== 7'h0) begin
        failures++;
        $display("FAIL overflow_err[%0d]: err=%b, required err[0]=%b", i, err_o, exp_err[i]);
      end
    end
    tick(); event_i = '0;
`ifdef SOC_EVT_QUEUE_STICKY_ERR_EN
    #1;
    checks++;
    if (err_sticky_o !== 8'h01) begin
      failures++;
      $display("FAIL sticky_set: sticky=%b, required 00000001", err_sticky_o);
    end
`endif
    evt_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (evt_valid_o !== 1'b1 || evt_id_o !== 3'd0) begin
        failures++;
        $display("FAIL overflow_drain[%0d]: valid=%b id=%0d, required 1/0", i, evt_valid_o, evt_id_o);
      end
      tick();
    end
    #1;
    checks++;
    if (evt_valid_o !== 1'b0 || pending_o !== 8'h00) begin
      failures++;
      $display("FAIL overflow_empty: valid=%b pend=%b, required 0/00", evt_valid_o, pending_o);
    end
`ifdef SOC_EVT_QUEUE_STICKY_ERR_EN
    err_clr_i = 8'h01;
    tick(); err_clr_i = '0; #1;
    checks++;
    if (err_sticky_o !== 8'h00) begin
      failures++;
      $display("FAIL sticky_clr: sticky=%b, required 0", err_sticky_o);
    end
`endif
    evt_ready_i = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [ID_W-1:0] exp_id [6];
    exp_id = '{3'd1, 3'd2, 3'd5, 3'd1, 3'd2, 3'd5};
    do_reset();
    tick(); event_i = 8'h26;
    tick();
    tick(); event_i = '0; evt_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (evt_valid_o !== 1'b1 || evt_id_o !== exp_id[i]) begin
        failures++;
        $display("FAIL rr_seq[%0d]: valid=%b id=%0d, required 1/%0d", i, evt_valid_o, evt_id_o, exp_id[i]);
      end
      tick();
    end
    #1;
    checks++;
    if (evt_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rr_end: valid=%b, required 0", evt_valid_o);
    end
    evt_ready_i = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    tick(); event_i = 8'h10;
    tick(); event_i = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      event_i = (i == 0) ? 8'h01 : (i == 2) ? 8'h40 : 8'h00;
      #1;
      checks++;
      if (evt_valid_o !== 1'b1 || evt_id_o !== 3'd4) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b id=%0d, required 1/4", i, evt_valid_o, evt_id_o);
      end
    end
    tick(); event_i = '0; evt_ready_i = 1'b1; #1;
    checks++;
    if (evt_id_o !== 3'd4) begin
      failures++;
      $display("FAIL stall_accept: id=%0d, required 4", evt_id_o);
    end
    tick(); #1;
    checks++;
    if (evt_valid_o !== 1'b1 || evt_id_o !== 3'd6) begin
      failures++;
      $display("FAIL stall_next6: valid=%b id=%0d, required 1/6", evt_valid_o, evt_id_o);
    end
    tick(); #1;
    checks++;
    if (evt_valid_o !== 1'b1 || evt_id_o !== 3'd0) begin
      failures++;
      $display("FAIL stall_next0: valid=%b id=%0d, required 1/0", evt_valid_o, evt_id_o);
    end
    tick(); #1;
    checks++;
    if (evt_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_end: valid=%b, required 0", evt_valid_o);
    end
    evt_ready_i = 1'b0;
  endtask

  task automatic test_inc_pop();
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(); event_i = 8'h04;
    end
    tick(); event_i = 8'h04; evt_ready_i = 1'b1; #1;
    checks++;
    if (err_o !== 8'h00 || evt_valid_o !== 1'b1 || evt_id_o !== 3'd2) begin
      failures++;
      $display("FAIL incpop_same: err=%b valid=%b id=%0d, required 00/1/2", err_o, evt_valid_o, evt_id_o);
    end
    // Count must still be full: one more event without a pop is dropped.
    tick(); event_i = 8'h04; evt_ready_i = 1'b0; #1;
    checks++;
    if (err_o !== 8'h04) begin
      failures++;
      $display("FAIL incpop_full: err=%b, required 00000100", err_o);
    end
    tick(); event_i = '0; evt_ready_i = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (evt_valid_o === 1'b1) n++;
      tick();
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL incpop_drain: accepted=%0d, required 4", n);
    end
    evt_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    tick(); event_i = 8'h4A;
    tick(); event_i = '0;
    tick(); #1;
    checks++;
    if (evt_valid_o !== 1'b1 || pending_o !== 8'h4A) begin
      failures++;
      $display("FAIL rst_pre: valid=%b pend=%b, required 1/4a", evt_valid_o, pending_o);
    end
    rstn_i = 1'b0; #1;
    checks++;
    if (evt_valid_o !== 1'b0 || pending_o !== 8'h00 || err_o !== 8'h00) begin
      failures++;
      $display("FAIL rst_async: valid=%b pend=%b err=%b, required 0", evt_valid_o, pending_o, err_o);
    end
    tick(); rstn_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      checks++;
      if (evt_valid_o !== 1'b0 || pending_o !== 8'h00) begin
        failures++;
        $display("FAIL rst_quiet[%0d]: valid=%b pend=%b, required 0", i, evt_valid_o, pending_o);
      end
    end
    tick(); event_i = 8'h80;
    tick(); event_i = '0;
    tick(); #1;
    checks++;
    if (evt_valid_o !== 1'b1 || evt_id_o !== 3'd7) begin
      failures++;
      $display("FAIL rst_new: valid=%b id=%0d, required 1/7", evt_valid_o, evt_id_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_stall();
    test_inc_pop();
    test_reset_mid_offer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soc_event_queue_rr.md
Name: soc_event_queue_rr

Overview:
- Multi-channel SoC event buffer with one saturating pending-event counter per channel, each QUEUE_SIZE deep.
- A round-robin arbiter drains the pending events through a single valid/ready port, presenting the source channel ID with each event.
- Sits between the peripheral event lines and the event/FC consumer. It replaces per-line event-queue instances followed by external arbitration.

Parameters:
- NB_CH, 8, number of event channels (>=1).
- QUEUE_SIZE, 4, maximum pending events per channel (>=1).
- CNT_W, $clog2(QUEUE_SIZE+1), localparam, per-channel counter width.
- ID_W, (NB_CH>1 ? $clog2(NB_CH) : 1), localparam, channel ID width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- event_i  in  NB_CH  single-cycle event pulses, one bit per channel; a bit high for N cycles counts as N events.
- err_o  out  NB_CH  overflow pulse per channel; the event was dropped.
- pending_o  out  NB_CH  per-channel count != 0, from registered counts.
- evt_valid_o  out  1  event offered to the consumer.
- evt_id_o  out  ID_W  channel of the offered event.
- evt_ready_i  in  1  consumer accepts; handshake = evt_valid_o & evt_ready_i.

Behaviour:
- Reset: all counters 0, rr_ptr 0, FSM IDLE, evt_valid_o 0, evt_id_o 0, err_o 0, pending_o 0. Reset is asynchronous and clears everything mid-offer; in-flight events are lost.
- Per channel c: inc = event_i[c]; pop = handshake & (evt_id_o == c).
  - inc & !pop: if cnt < QUEUE_SIZE then cnt+1, else cnt holds.
  - pop & !inc: cnt-1. pop only occurs with cnt >= 1; no underflow.
  - inc & pop: cnt holds (net zero, nothing dropped).
- err_o[c] = inc & !pop & (cnt == QUEUE_SIZE). It is combinational in the same cycle as the dropped event and is a one-cycle pulse per dropped event.
- Arbitration pick: the first channel with next-cycle count != 0, searched from rr_ptr upward, wrapping NB_CH-1 -> 0.
- FSM IDLE:
  - evt_valid_o = 0.
  - If any registered count != 0: latch evt_id_o = pick over the registered counts, go to OFFER.
- FSM OFFER:
  - evt_valid_o = 1. evt_id_o is held stable until the handshake, regardless of new events on other channels.
  - On handshake: rr_ptr <= (evt_id_o+1) mod NB_CH.
  - Then, if any channel's post-update count != 0: latch the new pick (search from the updated rr_ptr), stay in OFFER; this gives back-to-back transfers at 1 per cycle.
  - Otherwise go to IDLE.
- Outputs are registered: evt_valid_o and evt_id_o come from flops, pending_o from counter flops.
- Latency:
  - event_i at cycle t -> pending_o at t+1 -> evt_valid_o at t+2 (from IDLE).
  - Minimum event-to-accept time is 2 cycles.
- Fairness: after channel k is served, every other pending channel is served before k again.
- NB_CH=1: evt_id_o is constant 0 and rr_ptr is unused. The block then behaves as a single deep queue with a registered valid.
- Throughput per channel: when QUEUE_SIZE events are pending and the channel pulses continuously while being served, no error is raised on the cycles where pop coincides with inc.

Optional Feature:
- Macro SOC_EVT_QUEUE_STICKY_ERR_EN.
- Defined: adds ports err_sticky_o (out, NB_CH) and err_clr_i (in, NB_CH).
  - err_sticky_o[c] is set on err_o[c] and cleared on err_clr_i[c]; set wins on a simultaneous set and clear.
  - Reset value is 0. The bit is registered, so it is visible the cycle after the drop.
- Undefined: these ports and flops are absent; overflow is reported only by the err_o pulses.

Test Plan:
- Single event: event_i[3] pulsed at t0, evt_ready_i=1 -> pending_o[3]=1 at t0+1, evt_valid_o=1 with evt_id_o=3 at t0+2, handshake, then evt_valid_o=0 and pending_o=0 at t0+3.
- Overflow: QUEUE_SIZE=4, evt_ready_i=0, event_i[0] high for 6 cycles -> cnt saturates at 4, err_o[0] pulses on the 5th and 6th cycles; then 4 handshakes deliver ID 0 four times and evt_valid_o drops.
- Round-robin: channels 1, 2 and 5 hold 2 events each, evt_ready_i=1 -> evt_id_o sequence 1,2,5,1,2,5 back-to-back with no idle cycles.
- Stall stability: ID 4 offered, evt_ready_i=0 for 5 cycles while event_i[0] and event_i[6] fire -> evt_id_o stays 4 and evt_valid_o stays 1 throughout; after acceptance the next ID is 6, then 0.
- Simultaneous inc/pop: channel 2 full (4), offered, evt_ready_i=1 with event_i[2]=1 in the same cycle -> cnt stays 4, err_o[2]=0.
- Reset mid-offer: rstn_i low while evt_valid_o=1 with 3 channels pending -> evt_valid_o, pending_o and err_o go to 0 immediately; after release, no events are offered until new event_i pulses arrive.
